// File: rtl/serial_adder.sv
// serial_adder -- bit-serial adder/subtractor.
//
// One full-adder slice is reused over WIDTH clock cycles, LSB first, with a
// registered carry between steps. A controller issues one operation at a
// time with start_i and collects the result when done_o pulses.
//
// Ports:
//   clk_i    clock, all state changes on the rising edge
//   rst_i    asynchronous active-high reset, clears all state
//   start_i  operation request, sampled only while busy_o is low
//   sub_i    mode, sampled with start_i: 0 = A+B, 1 = A-B
//   a_i      operand A (WIDTH bits), sampled with start_i
//   b_i      operand B (WIDTH bits), sampled with start_i
//   sum_o    last completed result (WIDTH bits)
//   cout_o   carry out of the MSB (for subtraction: 1 = no borrow, A >= B)
//   ovf_o    two's-complement overflow of the last result
//   busy_o   high while an operation is in progress
//   done_o   one-cycle pulse, sum_o/cout_o/ovf_o updated in the same cycle
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // The single full-adder slice.
  logic s_bit;
  logic c_out;
  assign s_bit = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign c_out = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    c_d     = c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          a_sr_d  = a_i;
          b_sr_d  = sub_i ? ~b_i : b_i;
          c_d     = sub_i;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d    = c_out;
        res_d  = {s_bit, res_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          // On the MSB step c_q is the carry into the MSB, so overflow is
          // the XOR of that carry and the carry out of the MSB.
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_out;
          ovf_d   = c_q ^ c_out;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
  assign busy_o = (state_q == RUN);
  assign done_o = done_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk;
  logic clk_en;
  logic rst;

  // WIDTH=8 instance signals
  logic       start8, sub8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, ovf8, busy8, done8;

  // WIDTH=2 instance signals
  logic       start2, sub2;
  logic [1:0] a2, b2, sum2;
  logic       cout2, ovf2, busy2, done2;

  exp_t sb8[$];
  exp_t sb2[$];

  int n_pass;
  int n_total;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .sub_i(sub8),
    .a_i(a8), .b_i(b8), .sum_o(sum8), .cout_o(cout8), .ovf_o(ovf8),
    .busy_o(busy8), .done_o(done8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .sub_i(sub2),
    .a_i(a2), .b_i(b2), .sum_o(sum2), .cout_o(cout2), .ovf_o(ovf2),
    .busy_o(busy2), .done_o(done2)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Whole-word reference: A + (B or ~B) + SUB, modulo 2^w.
  function automatic exp_t model(input int w, input logic [7:0] a,
                                 input logic [7:0] b, input logic sub);
    logic [8:0] mask;
    logic [8:0] bb;
    logic [8:0] tot;
    exp_t e;
    mask = 9'((1 << w) - 1);
    bb   = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    tot  = ({1'b0, a} & mask) + bb + {8'd0, sub};
    e.sum  = tot[7:0] & mask[7:0];
    e.cout = tot[w];
    e.ovf  = (a[w-1] == bb[w-1]) && (tot[w-1] != a[w-1]);
    return e;
  endfunction

  // Drives one START edge on the 8-bit unit; returns 1 ns after that edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b,
                           input logic sub, input logic [7:0] es,
                           input logic ec, input logic eo);
    exp_t e;
    e.sum = es; e.cout = ec; e.ovf = eo;
    sb8.push_back(e);
    a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    $display("start8 a=%02h b=%02h sub=%0d", a, b, sub);
  endtask

  // Waits for DONE on the 8-bit unit, n0 edges already elapsed since START.
  task automatic collect8(input int n0, input string name);
    int n;
    exp_t e;
    n = n0;
    while (done8 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    e = '0;
    if (sb8.size() > 0) e = sb8.pop_front();
    $display("done8 %s sum=%02h cout=%0d ovf=%0d edges=%0d", name, sum8, cout8, ovf8, n);
    n_total++;
    if (n !== 8) $display("FAIL %s latency got %0d edges want 8", name, n);
    else n_pass++;
    n_total++;
    if (sum8 !== e.sum) $display("FAIL %s sum got %02h want %02h", name, sum8, e.sum);
    else n_pass++;
    n_total++;
    if (cout8 !== e.cout) $display("FAIL %s cout got %0d want %0d", name, cout8, e.cout);
    else n_pass++;
    n_total++;
    if (ovf8 !== e.ovf) $display("FAIL %s ovf got %0d want %0d", name, ovf8, e.ovf);
    else n_pass++;
    n_total++;
    if (busy8 !== 1'b0) $display("FAIL %s busy_with_done got %0d want 0", name, busy8);
    else n_pass++;
  endtask

  task automatic test_reset();
    clk_en = 1'b0;
    rst = 1'b1;
    #3;
    n_total++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'd0)
      $display("FAIL reset8 outputs got %03h want 000", {sum8, cout8, ovf8, busy8, done8});
    else n_pass++;
    n_total++;
    if ({sum2, cout2, ovf2, busy2, done2} !== 6'd0)
      $display("FAIL reset2 outputs got %02h want 00", {sum2, cout2, ovf2, busy2, done2});
    else n_pass++;
    $display("reset sum8=%02h busy8=%0d done8=%0d", sum8, busy8, done8);
    rst = 1'b0;
    clk_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    start_op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    collect8(0, "add_0F_01");
    start_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    collect8(0, "add_FF_01");
    start_op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    collect8(0, "add_7F_01");
    @(posedge clk); #1;
    n_total++;
    if (done8 !== 1'b0) $display("FAIL done_fall got %0d want 0", done8);
    else n_pass++;
    n_total++;
    if (sum8 !== 8'h80) $display("FAIL hold_after_done got %02h want 80", sum8);
    else n_pass++;
  endtask

  task automatic test_sub();
    start_op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    collect8(0, "sub_05_07");
    start_op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    collect8(0, "sub_80_01");
    start_op8(8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0);
    collect8(0, "sub_33_33");
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    start_op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Request while busy: must be ignored.
    a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_total++;
    if (busy8 !== 1'b1) $display("FAIL busy_during_run got %0d want 1", busy8);
    else n_pass++;
    collect8(3, "ignore_start");
    // START in the DONE cycle.
    start_op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (sum8 !== 8'h30 || done8 !== 1'b0)
        $display("FAIL hold_cycle%0d sum got %02h done %0d want 30 0", i, sum8, done8);
      else n_pass++;
    end
    collect8(7, "b2b_01_01");
    @(posedge clk); #1;
    n_total++;
    if (busy8 !== 1'b0) $display("FAIL ignored_start_leak got busy %0d want 0", busy8);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_total++;
    if (busy8 !== 1'b0) $display("FAIL abort_busy got %0d want 0", busy8);
    else n_pass++;
    n_total++;
    if ({sum8, cout8, ovf8} !== 10'd0) $display("FAIL abort_clear got %03h want 000", {sum8, cout8, ovf8});
    else n_pass++;
    rst = 1'b0;
    $display("abort busy8=%0d sum8=%02h", busy8, sum8);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (done8 !== 1'b0 || sum8 !== 8'h00)
        $display("FAIL abort_idle%0d done got %0d sum %02h want 0 00", i, done8, sum8);
      else n_pass++;
    end
    start_op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    collect8(0, "after_abort");
    @(posedge clk); #1;
  endtask

  task automatic test_sweep_w2();
    exp_t e;
    int n;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          sb2.push_back(model(2, 8'(a), 8'(b), 1'(s)));
          a2 = 2'(a); b2 = 2'(b); sub2 = 1'(s); start2 = 1'b1;
          @(posedge clk); #1;
          start2 = 1'b0;
          n = 0;
          while (done2 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
          end
          e = sb2.pop_front();
          $display("done2 a=%0d b=%0d sub=%0d sum=%0d cout=%0d ovf=%0d edges=%0d",
                   a, b, s, sum2, cout2, ovf2, n);
          n_total++;
          if (n !== 2 || sum2 !== e.sum[1:0] || cout2 !== e.cout || ovf2 !== e.ovf)
            $display("FAIL w2 a=%0d b=%0d sub=%0d got sum %0d cout %0d ovf %0d edges %0d want %0d %0d %0d 2",
                     a, b, s, sum2, cout2, ovf2, n, e.sum[1:0], e.cout, e.ovf);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    rst = 1'b0; clk_en = 1'b0;
    #1;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_mid_reset();
    test_sweep_w2();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
